// File: rtl/cuckoo_lookup.sv
// Two-table cuckoo hash lookup: probes table 1, then table 2, and reports the hit slot.
// Optional single-cycle slot clear on hit is built when CUCKOO_LOOKUP_DELETE_EN is defined.
module cuckoo_lookup #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    input  logic [IDX_W-1:0] req_idx1,
    input  logic [IDX_W-1:0] req_idx2,
`ifdef CUCKOO_LOOKUP_DELETE_EN
    input  logic             req_del,
    output logic             clr_en,
    output logic             clr_table,
    output logic [IDX_W-1:0] clr_addr,
`endif
    output logic             t1_rd_en,
    output logic [IDX_W-1:0] t1_rd_addr,
    input  logic [KEY_W-1:0] t1_rd_data,
    input  logic             t1_rd_filled,
    output logic             t2_rd_en,
    output logic [IDX_W-1:0] t2_rd_addr,
    input  logic [KEY_W-1:0] t2_rd_data,
    input  logic             t2_rd_filled,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_table,
    output logic [IDX_W-1:0] rsp_index
);

    // state | meaning
    // IDLE  | ready for a request
    // RD1   | table-1 read issued
    // CMP1  | table-1 data compared
    // RD2   | table-2 read issued
    // CMP2  | table-2 data compared
    // DEL   | clear pulse for the hit slot (delete builds only)
    // RESP  | result held until rsp_ready
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        CMP1 = 3'd2,
        RD2  = 3'd3,
        CMP2 = 3'd4,
`ifdef CUCKOO_LOOKUP_DELETE_EN
        DEL  = 3'd6,
`endif
        RESP = 3'd5
    } state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [IDX_W-1:0]   idx1_q;
    logic [IDX_W-1:0]   idx2_q;
    logic               req_ready_q;
    logic               t1_rd_en_q;
    logic [IDX_W-1:0]   t1_rd_addr_q;
    logic               t2_rd_en_q;
    logic [IDX_W-1:0]   t2_rd_addr_q;
    logic               rsp_valid_q;
    logic               rsp_hit_q;
    logic               rsp_table_q;
    logic [IDX_W-1:0]   rsp_index_q;
`ifdef CUCKOO_LOOKUP_DELETE_EN
    logic               del_q;
    logic               clr_en_q;
    logic               clr_table_q;
    logic [IDX_W-1:0]   clr_addr_q;
`endif

    logic hit1;
    logic hit2;

    // Occupancy comes only from the filled bit, so a key of zero is an ordinary key.
    assign hit1 = t1_rd_filled && (t1_rd_data == key_q);
    assign hit2 = t2_rd_filled && (t2_rd_data == key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            idx1_q       <= '0;
            idx2_q       <= '0;
            req_ready_q  <= 1'b0;
            t1_rd_en_q   <= 1'b0;
            t1_rd_addr_q <= '0;
            t2_rd_en_q   <= 1'b0;
            t2_rd_addr_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_table_q  <= 1'b0;
            rsp_index_q  <= '0;
`ifdef CUCKOO_LOOKUP_DELETE_EN
            del_q        <= 1'b0;
            clr_en_q     <= 1'b0;
            clr_table_q  <= 1'b0;
            clr_addr_q   <= '0;
`endif
        end else begin
            t1_rd_en_q   <= 1'b0;
            t1_rd_addr_q <= '0;
            t2_rd_en_q   <= 1'b0;
            t2_rd_addr_q <= '0;
`ifdef CUCKOO_LOOKUP_DELETE_EN
            clr_en_q     <= 1'b0;
            clr_table_q  <= 1'b0;
            clr_addr_q   <= '0;
`endif
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        key_q        <= req_key;
                        idx1_q       <= req_idx1;
                        idx2_q       <= req_idx2;
`ifdef CUCKOO_LOOKUP_DELETE_EN
                        del_q        <= req_del;
`endif
                        req_ready_q  <= 1'b0;
                        t1_rd_en_q   <= 1'b1;
                        t1_rd_addr_q <= req_idx1;
                        state_q      <= RD1;
                    end
                end
                RD1: state_q <= CMP1;
                CMP1: begin
                    if (hit1) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_table_q <= 1'b0;
                        rsp_index_q <= idx1_q;
`ifdef CUCKOO_LOOKUP_DELETE_EN
                        if (del_q) begin
                            clr_en_q    <= 1'b1;
                            clr_table_q <= 1'b0;
                            clr_addr_q  <= idx1_q;
                            state_q     <= DEL;
                        end else
`endif
                        begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else begin
                        t2_rd_en_q   <= 1'b1;
                        t2_rd_addr_q <= idx2_q;
                        state_q      <= RD2;
                    end
                end
                RD2: state_q <= CMP2;
                CMP2: begin
                    rsp_hit_q   <= hit2;
                    rsp_table_q <= hit2;
                    rsp_index_q <= hit2 ? idx2_q : '0;
`ifdef CUCKOO_LOOKUP_DELETE_EN
                    if (hit2 && del_q) begin
                        clr_en_q    <= 1'b1;
                        clr_table_q <= 1'b1;
                        clr_addr_q  <= idx2_q;
                        state_q     <= DEL;
                    end else
`endif
                    begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
`ifdef CUCKOO_LOOKUP_DELETE_EN
                DEL: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_hit_q   <= 1'b0;
                        rsp_table_q <= 1'b0;
                        rsp_index_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign t1_rd_en   = t1_rd_en_q;
    assign t1_rd_addr = t1_rd_addr_q;
    assign t2_rd_en   = t2_rd_en_q;
    assign t2_rd_addr = t2_rd_addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_table  = rsp_table_q;
    assign rsp_index  = rsp_index_q;
`ifdef CUCKOO_LOOKUP_DELETE_EN
    assign clr_en     = clr_en_q;
    assign clr_table  = clr_table_q;
    assign clr_addr   = clr_addr_q;
`endif

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Scoreboard bench for cuckoo_lookup; table memories are modelled with one-cycle read latency.
// Delete scenarios are included when CUCKOO_LOOKUP_DELETE_EN is defined.
module tb_cuckoo_lookup;
    localparam int KW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [KW-1:0] req_key = '0;
    logic [IW-1:0] req_idx1 = '0;
    logic [IW-1:0] req_idx2 = '0;
    logic          t1_rd_en, t2_rd_en;
    logic [IW-1:0] t1_rd_addr, t2_rd_addr;
    logic [KW-1:0] t1_rd_data, t2_rd_data;
    logic          t1_rd_filled, t2_rd_filled;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit, rsp_table;
    logic [IW-1:0] rsp_index;
`ifdef CUCKOO_LOOKUP_DELETE_EN
    logic          req_del = 1'b0;
    logic          clr_en, clr_table;
    logic [IW-1:0] clr_addr;
    int            clr_cnt = 0;
    logic          clr_last_table = 1'b0;
    logic [IW-1:0] clr_last_addr = '0;
`endif

    always #5 clk = ~clk;

    cuckoo_lookup #(.KEY_W(KW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .req_idx1(req_idx1), .req_idx2(req_idx2),
`ifdef CUCKOO_LOOKUP_DELETE_EN
        .req_del(req_del), .clr_en(clr_en), .clr_table(clr_table), .clr_addr(clr_addr),
`endif
        .t1_rd_en(t1_rd_en), .t1_rd_addr(t1_rd_addr), .t1_rd_data(t1_rd_data), .t1_rd_filled(t1_rd_filled),
        .t2_rd_en(t2_rd_en), .t2_rd_addr(t2_rd_addr), .t2_rd_data(t2_rd_data), .t2_rd_filled(t2_rd_filled),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_table(rsp_table), .rsp_index(rsp_index)
    );

    logic [KW-1:0] t1_mem [32];
    logic [KW-1:0] t2_mem [32];
    logic          t1_fill [32];
    logic          t2_fill [32];

    // Outside a read response the data lines carry filled noise, so a compare in the wrong cycle shows up.
    always @(posedge clk) begin
        if (t1_rd_en) begin
            t1_rd_data   <= t1_mem[t1_rd_addr];
            t1_rd_filled <= t1_fill[t1_rd_addr];
        end else begin
            t1_rd_data   <= $urandom;
            t1_rd_filled <= 1'b1;
        end
        if (t2_rd_en) begin
            t2_rd_data   <= t2_mem[t2_rd_addr];
            t2_rd_filled <= t2_fill[t2_rd_addr];
        end else begin
            t2_rd_data   <= $urandom;
            t2_rd_filled <= 1'b1;
        end
    end

    int            t1_pulses = 0, t2_pulses = 0, addr_bad = 0;
    logic [IW-1:0] t1_last = '0, t2_last = '0;

    always @(negedge clk) begin
        if (t1_rd_en) begin t1_pulses++; t1_last = t1_rd_addr; end
        else if (t1_rd_addr != '0) addr_bad++;
        if (t2_rd_en) begin t2_pulses++; t2_last = t2_rd_addr; end
        else if (t2_rd_addr != '0) addr_bad++;
        if (rsp_valid && req_ready) addr_bad++;
`ifdef CUCKOO_LOOKUP_DELETE_EN
        if (clr_en) begin clr_cnt++; clr_last_table = clr_table; clr_last_addr = clr_addr; end
`endif
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic          hit;
        logic          tab;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;
    exp_t sb[$];

    task automatic lookup(input logic [KW-1:0] key, input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                          input logic eh, input logic et, input logic [IW-1:0] ei, input int elat,
                          input int hold, input int exp_t1, input int exp_t2);
        int   a1, a2, n, lat;
        exp_t e;
        a1 = t1_pulses;
        a2 = t2_pulses;
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = key;
        req_idx1  = i1;
        req_idx2  = i2;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", 64'(n), 64'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{hit: eh, tab: et, idx: ei, lat: elat});
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'(lat), 64'(e.lat));
            return;
        end
        chk("latency", 64'(lat), 64'(e.lat));
        chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
        chk("rsp_table", 64'(rsp_table), 64'(e.tab));
        chk("rsp_index", 64'(rsp_index), 64'(e.idx));
        chk("ready_in_resp", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_key   = $urandom;
            req_idx1  = 5'd1;
            req_idx2  = 5'd2;
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_fields", {61'd0, rsp_hit, rsp_table}, {61'd0, e.hit, e.tab});
            chk("hold_index", 64'(rsp_index), 64'(e.idx));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("ready_back", 64'(req_ready), 64'd1);
        chk("t1_reads", 64'(t1_pulses - a1), 64'(exp_t1));
        chk("t2_reads", 64'(t2_pulses - a2), 64'(exp_t2));
        if (exp_t1 > 0) chk("t1_addr", 64'(t1_last), 64'(i1));
        if (exp_t2 > 0) chk("t2_addr", 64'(t2_last), 64'(i2));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            t1_mem[i] = '0; t2_mem[i] = '0; t1_fill[i] = 1'b0; t2_fill[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rd_en", {62'd0, t1_rd_en, t2_rd_en}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        t1_mem[3] = 32'hDEADBEEF; t1_fill[3] = 1'b1;
        lookup(32'hDEADBEEF, 5'd3, 5'd9, 1'b1, 1'b0, 5'd3, 3, 0, 1, 0);

        t1_mem[3] = 32'h1; t2_mem[9] = 32'hCAFE0001; t2_fill[9] = 1'b1;
        lookup(32'hCAFE0001, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 5, 0, 1, 1);

        t1_mem[4] = 32'h55; t1_fill[4] = 1'b0;
        lookup(32'h55, 5'd4, 5'd7, 1'b0, 1'b0, 5'd0, 5, 0, 1, 1);

        t1_mem[5] = 32'hAB; t1_fill[5] = 1'b1; t2_mem[6] = 32'hAB; t2_fill[6] = 1'b1;
        lookup(32'hAB, 5'd5, 5'd6, 1'b1, 1'b0, 5'd5, 3, 0, 1, 0);

        t1_fill[10] = 1'b0; t2_mem[0] = 32'h0; t2_fill[0] = 1'b1;
        lookup(32'h0, 5'd10, 5'd0, 1'b1, 1'b1, 5'd0, 5, 0, 1, 1);

        t1_mem[31] = 32'h7777_0031; t1_fill[31] = 1'b1;
        lookup(32'h7777_0031, 5'd31, 5'd30, 1'b1, 1'b0, 5'd31, 3, 10, 1, 0);

        t2_mem[30] = 32'h1234_5678; t2_fill[30] = 1'b1;
        lookup(32'h1234_5678, 5'd12, 5'd30, 1'b1, 1'b1, 5'd30, 5, 4, 1, 1);

        // Reset while the table-1 compare is in progress.
        @(negedge clk);
        req_valid = 1'b1; req_key = 32'hDEADBEEF; req_idx1 = 5'd3; req_idx2 = 5'd9;
        t1_mem[3] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_rsp", {61'd0, rsp_valid, rsp_hit, rsp_table}, 64'd0);
        chk("midrst_index", 64'(rsp_index), 64'd0);
        chk("midrst_rd", {52'd0, t1_rd_en, t2_rd_en, t1_rd_addr, t2_rd_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_back", 64'(req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        lookup(32'hDEADBEEF, 5'd3, 5'd9, 1'b1, 1'b0, 5'd3, 3, 0, 1, 0);

`ifdef CUCKOO_LOOKUP_DELETE_EN
        begin
            int c0;
            c0 = clr_cnt;
            req_del = 1'b1;
            lookup(32'hCAFE0001, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 6, 0, 1, 1);
            chk("clr_pulses", 64'(clr_cnt - c0), 64'd1);
            chk("clr_table", 64'(clr_last_table), 64'd1);
            chk("clr_addr", 64'(clr_last_addr), 64'd9);
            c0 = clr_cnt;
            lookup(32'hDEADBEEF, 5'd3, 5'd9, 1'b1, 1'b0, 5'd3, 4, 0, 1, 0);
            chk("clr_t1_pulses", 64'(clr_cnt - c0), 64'd1);
            chk("clr_t1_table", 64'(clr_last_table), 64'd0);
            chk("clr_t1_addr", 64'(clr_last_addr), 64'd3);
            c0 = clr_cnt;
            lookup(32'h55, 5'd4, 5'd7, 1'b0, 1'b0, 5'd0, 5, 0, 1, 1);
            chk("clr_on_miss", 64'(clr_cnt - c0), 64'd0);
            req_del = 1'b0;
            c0 = clr_cnt;
            lookup(32'hCAFE0001, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 5, 0, 1, 1);
            chk("clr_without_del", 64'(clr_cnt - c0), 64'd0);
        end
`endif

        chk("idle_addr_and_overlap", 64'(addr_bad), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
